// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline stage registers.
// Skid-buffer state encoding and payload width helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF  = 64;
  localparam int unsigned CTRL_W_DEF  = 16;
  localparam int unsigned STALL_W_DEF = 16;

  function automatic int unsigned payload_width(
    input int unsigned iw,
    input int unsigned dw,
    input int unsigned cw
  );
    return iw + 3 * dw + cw;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register.
// Load enable plus synchronous clear.
module pipe_payload_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // hold payload; clear wins over load
  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with 2-entry skid buffer.
// Registered in_ready, flush squash, saturating stall counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = INSTR_W_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_W_DEF,
  parameter int unsigned CONTROL_WIDTH = CTRL_W_DEF,
  parameter int unsigned STALL_CNT_W   = STALL_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   pc_in,
  input  logic [DATA_WIDTH-1:0]    val_a_in,
  input  logic [DATA_WIDTH-1:0]    val_b_in,
  input  logic [DATA_WIDTH-1:0]    imm_in,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_WIDTH-1:0]   pc_out,
  output logic [DATA_WIDTH-1:0]    val_a_out,
  output logic [DATA_WIDTH-1:0]    val_b_out,
  output logic [DATA_WIDTH-1:0]    imm_out,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  localparam int unsigned PW =
    payload_width(INSTR_WIDTH, DATA_WIDTH, CONTROL_WIDTH);

  skid_state_e            state_q, state_d;
  logic                   in_ready_q;
  logic                   accept, pop;
  logic                   load_main, load_skid;
  logic [PW-1:0]          in_pl, main_d, main_q, skid_q;
  logic [PW-1:0]          out_pl;
  logic [STALL_CNT_W-1:0] stall_q;

  assign in_pl  = {pc_in, val_a_in, val_b_in, imm_in, control_in};
  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;
  assign main_d = (state_q == TWO) ? skid_q : in_pl;

  // state and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // next state and entry loads; flush squashes everything
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .rst_i (reset),
    .clr_i (flush),
    .en_i  (load_main),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_i (reset),
    .clr_i (flush),
    .en_i  (load_skid),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

  // outputs: bubbles carry an all-zero payload
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_pl    = out_valid ? main_q : '0;
  end

  assign in_ready = in_ready_q;
  assign {pc_out, val_a_out, val_b_out, imm_out, control_out} = out_pl;

  // back-pressure counter, saturating, survives flush
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed and randomized checks for id_ex_pipe_reg.
// Second instance with 4-bit stall counter covers saturation.
module tb_id_ex_pipe_reg;

  localparam int IW = 32;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int PW = IW + 3 * DW + CW;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [IW-1:0] pc_in;
  logic [DW-1:0] val_a_in, val_b_in, imm_in;
  logic [CW-1:0] control_in;
  logic          in_ready, out_valid;
  logic [IW-1:0] pc_out;
  logic [DW-1:0] val_a_out, val_b_out, imm_out;
  logic [CW-1:0] control_out;
  logic [15:0]   stall_cycles;

  logic          s_in_ready, s_out_valid;
  logic [IW-1:0] s_pc_out;
  logic [DW-1:0] s_a_out, s_b_out, s_imm_out;
  logic [CW-1:0] s_ctl_out;
  logic [3:0]    s_stall;

  int cmp = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .val_a_in(val_a_in), .val_b_in(val_b_in),
    .imm_in(imm_in), .control_in(control_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .val_a_out(val_a_out), .val_b_out(val_b_out),
    .imm_out(imm_out), .control_out(control_out),
    .stall_cycles(stall_cycles)
  );

  id_ex_pipe_reg #(.STALL_CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .pc_in(pc_in), .val_a_in(val_a_in), .val_b_in(val_b_in),
    .imm_in(imm_in), .control_in(control_in),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .pc_out(s_pc_out), .val_a_out(s_a_out), .val_b_out(s_b_out),
    .imm_out(s_imm_out), .control_out(s_ctl_out),
    .stall_cycles(s_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; val_a_in = '0; val_b_in = '0;
    imm_in = '0; control_in = '0;
    reset = 1'b1;
    tick();
    in_valid = 1'b1; pc_in = 32'hDEAD;
    tick();
    cmp++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    cmp++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    cmp++; if (pc_out !== '0) begin bad++;
      $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    cmp++; if (stall_cycles !== '0) begin bad++;
      $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    logic [IW-1:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      pc_in = pcs[i];
      val_a_in = 64'(i + 1);
      tick();
      cmp++; if (out_valid !== 1'b1 || pc_out !== pcs[i]) begin bad++;
        $display("FAIL stream_pc[%0d] got v=%b pc=%h exp v=1 pc=%h",
                 i, out_valid, pc_out, pcs[i]); end
      cmp++; if (val_a_out !== 64'(i + 1)) begin bad++;
        $display("FAIL stream_a[%0d] got %h exp %h",
                 i, val_a_out, 64'(i + 1)); end
      cmp++; if (in_ready !== 1'b1) begin bad++;
        $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
    end
    in_valid = 1'b0;
    val_a_in = '0;
    tick();
    cmp++; if (out_valid !== 1'b0 || pc_out !== '0) begin bad++;
      $display("FAIL stream_drain got v=%b pc=%h exp v=0 pc=0",
               out_valid, pc_out); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; pc_in = 32'h200;
    tick();
    pc_in = 32'h204;
    tick();
    cmp++; if (in_ready !== 1'b0) begin bad++;
      $display("FAIL bp_ready_low got %b exp 0", in_ready); end
    in_valid = 1'b0;
    tick();
    cmp++; if (pc_out !== 32'h200 || in_ready !== 1'b0) begin bad++;
      $display("FAIL bp_hold got pc=%h rdy=%b exp pc=200 rdy=0",
               pc_out, in_ready); end
    cmp++; if (stall_cycles !== 16'd2) begin bad++;
      $display("FAIL bp_stall_held got %0d exp 2", stall_cycles); end
    out_ready = 1'b1;
    tick();
    cmp++; if (out_valid !== 1'b1 || pc_out !== 32'h204) begin bad++;
      $display("FAIL bp_second got v=%b pc=%h exp v=1 pc=204",
               out_valid, pc_out); end
    cmp++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_ready_back got %b exp 1", in_ready); end
    tick();
    cmp++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL bp_empty got %b exp 0", out_valid); end
    cmp++; if (stall_cycles !== 16'd2) begin bad++;
      $display("FAIL bp_stall_final got %0d exp 2", stall_cycles); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; pc_in = 32'h2F0;
    tick();
    pc_in = 32'h2F4;
    tick();
    pc_in = 32'h300;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp++; if (out_valid !== 1'b0 || pc_out !== '0) begin bad++;
      $display("FAIL flush_two got v=%b pc=%h exp v=0 pc=0",
               out_valid, pc_out); end
    cmp++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL flush_ready got %b exp 1", in_ready); end
    cmp++; if (stall_cycles !== 16'd4) begin bad++;
      $display("FAIL flush_stall got %0d exp 4", stall_cycles); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp++; if (out_valid !== 1'b0) begin bad++;
        $display("FAIL flush_no_300[%0d] got v=%b pc=%h exp v=0",
                 i, out_valid, pc_out); end
    end
    // flush in ONE with a same-cycle accept: both discarded
    in_valid = 1'b1; pc_in = 32'h310;
    tick();
    pc_in = 32'h314;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    cmp++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL flush_one_accept got v=%b pc=%h exp v=0",
               out_valid, pc_out); end
    tick();
    cmp++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL flush_one_after got v=%b pc=%h exp v=0",
               out_valid, pc_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; pc_in = 32'h400;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    cmp++; if (s_stall !== 4'd15) begin bad++;
      $display("FAIL sat_stall4 got %0d exp 15", s_stall); end
    cmp++; if (stall_cycles !== 16'd20) begin bad++;
      $display("FAIL sat_stall16 got %0d exp 20", stall_cycles); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp++; if (out_valid !== 1'b0 || stall_cycles !== '0) begin bad++;
      $display("FAIL reset_mid got v=%b st=%0d exp v=0 st=0",
               out_valid, stall_cycles); end
  endtask

  task automatic test_random();
    logic [PW-1:0] sb [$];
    logic [PW-1:0] got, pl;
    logic          acc, pp;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      got = {pc_out, val_a_out, val_b_out, imm_out, control_out};
      cmp++; if (out_valid !== (sb.size() != 0)) begin bad++;
        $display("FAIL rnd_valid@%0d got %b exp %b",
                 i, out_valid, sb.size() != 0); end
      cmp++; if (in_ready !== (sb.size() < 2)) begin bad++;
        $display("FAIL rnd_ready@%0d got %b exp %b",
                 i, in_ready, sb.size() < 2); end
      pl = (sb.size() != 0) ? sb[0] : '0;
      cmp++; if (got !== pl) begin bad++;
        $display("FAIL rnd_payload@%0d got pc=%h exp pc=%h",
                 i, pc_out, pl[PW-1 -: IW]); end
      in_valid   = ($urandom_range(99) < 60);
      out_ready  = ($urandom_range(99) < 60);
      flush      = ($urandom_range(99) < 3);
      pc_in      = $urandom;
      val_a_in   = {$urandom, $urandom};
      val_b_in   = {$urandom, $urandom};
      imm_in     = {$urandom, $urandom};
      control_in = 16'($urandom);
      acc = in_valid && (sb.size() < 2);
      pp  = out_ready && (sb.size() != 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (pp) void'(sb.pop_front());
        if (acc) sb.push_back({pc_in, val_a_in, val_b_in,
                               imm_in, control_in});
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
